// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Hardwired fetch/execute sequencer for the Mini SRC datapath. A state
//   register walks RESET_S -> T0..T7 -> (T0 | HALT_S); every datapath control
//   is a combinational function of the current state and the opcode field
//   IR[31:27] (plus CON_FF for the conditional PC load in a branch).
//
// Ports
//   Clock, Clear          : rising-edge clock, asynchronous active-low reset
//   IR[31:0]              : instruction register (only the opcode is decoded)
//   CON_FF                : branch condition flip-flop
//   Stop                  : stop request, honoured only between instructions
//   *out                  : bus drivers (at most one high per cycle)
//   *in                   : register load enables
//   IncPC, Read, Write    : PC increment, memory read/write strobes
//   Gra/Grb/Grc, Rin/Rout : register-file field select and enables
//   BAout, Cout, CONin    : base-address out, constant out, CON load
//   alu_op                : ALU select (opcode, or ADD_OP for address sums)
//   Run                   : high while sequencing instructions
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int            OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           InPortout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           OutPortin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           Cout,
  output logic           CONin,
  output logic [OPW-1:0] alu_op,
  output logic           Run
);

  typedef enum logic [3:0] {
    RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT_S
  } state_e;

  // Instruction classes sharing one micro-step sequence.
  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST,
    C_BR, C_IN, C_OUT, C_MFHI, C_MFLO
  } iclass_e;

  state_e        state_q, state_d;
  iclass_e       iclass;
  logic [OPW-1:0] op;
  logic          last_step;

  assign op = IR[31 -: OPW];

  // Operand fields are decoded by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^IR[31-OPW:0];

  always_comb begin
    case (op)
      5'b00000: iclass = C_LD;
      5'b00001: iclass = C_LDI;
      5'b00010: iclass = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010: iclass = C_ALU;
      5'b01011, 5'b01100, 5'b01101: iclass = C_IMM;
      5'b01110, 5'b01111: iclass = C_MULDIV;
      5'b10000, 5'b10001: iclass = C_UNARY;
      5'b10010: iclass = C_BR;
      5'b10101: iclass = C_IN;
      5'b10110: iclass = C_OUT;
      5'b10111: iclass = C_MFHI;
      5'b11000: iclass = C_MFLO;
      5'b11010: iclass = C_HALT;
      default:  iclass = C_NOP;   // nop and every unassigned opcode
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, regardless of block ordering.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= RESET_S;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    alu_op    = '0;
    last_step = 1'b0;
    state_d   = state_q;
    Run       = (state_q != RESET_S) && (state_q != HALT_S);

    case (state_q)
      RESET_S: state_d = T0;
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; state_d = T1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; state_d = T2; end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1; state_d = T3;
        if (iclass == C_HALT)     state_d = HALT_S;
        else if (iclass == C_NOP) last_step = 1'b1;
      end
      T3: begin
        state_d = T4;
        case (iclass)
          C_ALU, C_IMM:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_MULDIV:         begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UNARY:          begin Grb = 1'b1; Rout = 1'b1; alu_op = op; Zin = 1'b1; end
          C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BR:             begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          C_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; last_step = 1'b1; end
          C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        state_d = T5;
        case (iclass)
          C_ALU:             begin Grc = 1'b1; Rout = 1'b1; alu_op = op; Zin = 1'b1; end
          C_IMM:             begin Cout = 1'b1; alu_op = op; Zin = 1'b1; end
          C_MULDIV:          begin Grb = 1'b1; Rout = 1'b1; alu_op = op; Zin = 1'b1; end
          C_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          C_LD, C_LDI, C_ST: begin Cout = 1'b1; alu_op = ADD_OP; Zin = 1'b1; end
          C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
          default: last_step = 1'b1;
        endcase
      end
      T5: begin
        state_d = T6;
        case (iclass)
          C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last_step = 1'b1; end
          C_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
          C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
          C_BR:                begin Cout = 1'b1; alu_op = ADD_OP; Zin = 1'b1; end
          default: last_step = 1'b1;
        endcase
      end
      T6: begin
        state_d = T7;
        case (iclass)
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; last_step = 1'b1; end
          C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR:     begin Zlowout = 1'b1; PCin = CON_FF; last_step = 1'b1; end
          default:  last_step = 1'b1;
        endcase
      end
      T7: begin
        last_step = 1'b1;
        case (iclass)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      HALT_S:  state_d = HALT_S;
      default: state_d = RESET_S;
    endcase

    // Stop is only looked at once the current instruction has finished.
    if (last_step) state_d = Stop ? HALT_S : T0;
  end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Directed bench for control_unit. All control outputs are packed into one
//   28-bit vector (PCout in the MSB ... Run in the LSB) and compared cycle by
//   cycle against hand-written step patterns, sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [4:0] alu_op;
  logic Run;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .CONin(CONin),
    .alu_op(alu_op), .Run(Run)
  );

  always #5 Clock = ~Clock;

  logic [27:0] ctl;
  assign ctl = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout,
                MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin,
                IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
                CONin, Run};

  localparam logic [27:0] PCO  = 28'd1 << 27, ZHO  = 28'd1 << 26,
                          ZLO  = 28'd1 << 25, MDRO = 28'd1 << 24,
                          HIO  = 28'd1 << 23, LOO  = 28'd1 << 22,
                          INO  = 28'd1 << 21, MARI = 28'd1 << 20,
                          ZI   = 28'd1 << 19, PCI  = 28'd1 << 18,
                          MDRI = 28'd1 << 17, IRI  = 28'd1 << 16,
                          YI   = 28'd1 << 15, HII  = 28'd1 << 14,
                          LOI  = 28'd1 << 13, OPI  = 28'd1 << 12,
                          INC  = 28'd1 << 11, RD   = 28'd1 << 10,
                          WR   = 28'd1 << 9,  GRA  = 28'd1 << 8,
                          GRB  = 28'd1 << 7,  GRC  = 28'd1 << 6,
                          RIN  = 28'd1 << 5,  ROUT = 28'd1 << 4,
                          BAO  = 28'd1 << 3,  CO   = 28'd1 << 2,
                          CONI = 28'd1 << 1,  RUN  = 28'd1 << 0;

  localparam logic [27:0] F0 = PCO | MARI | INC | ZI | RUN;
  localparam logic [27:0] F1 = ZLO | PCI | RD | MDRI | RUN;
  localparam logic [27:0] F2 = MDRO | IRI | RUN;

  // Expected step table for the sequence under test; alu x = not checked.
  logic [27:0] e [10];
  logic [4:0]  a [10];
  int          n;

  task automatic next_cycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 10; i++) begin
      e[i] = '0;
      a[i] = 'x;
    end
    e[0] = F0; e[1] = F1; e[2] = F2;
  endtask

  // Returns to T0 through a short reset pulse (no comparisons here).
  task automatic do_reset();
    Clear = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    Clear = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (ctl !== 28'd0 || alu_op !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle: ctl=%h alu=%b, expected 0000000 00000", ctl, alu_op);
    end
    Clear = 1'b1;
    next_cycle();
    checks++;
    if (ctl !== F0) begin
      errors++;
      $display("FAIL reset_to_t0: ctl=%h expected %h", ctl, F0);
    end
  endtask

  task automatic test_add();
    IR = 32'h1891_8000;
    clear_exp();
    e[3] = GRB | ROUT | YI | RUN;
    e[4] = GRC | ROUT | ZI | RUN;  a[4] = 5'b00011;
    e[5] = ZLO | GRA | RIN | RUN;
    e[6] = F0;
    n = 7;
    for (int i = 0; i < n; i++) begin
      if (i > 0) next_cycle();
      checks++;
      if (ctl !== e[i] || (!$isunknown(a[i]) && alu_op !== a[i])) begin
        errors++;
        $display("FAIL add step %0d: ctl=%h alu=%b, expected ctl=%h alu=%b", i, ctl, alu_op, e[i], a[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    IR = 32'h1891_8000;
    for (int i = 0; i < 5; i++) next_cycle();
    checks++;
    if (ctl !== (ZLO | GRA | RIN | RUN)) begin
      errors++;
      $display("FAIL reset_mid_t5: ctl=%h expected %h", ctl, ZLO | GRA | RIN | RUN);
    end
    Clear = 1'b0;
    #1;
    checks++;
    if (ctl !== 28'd0 || alu_op !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_async: ctl=%h alu=%b, expected 0", ctl, alu_op);
    end
    next_cycle();
    checks++;
    if (ctl !== 28'd0) begin
      errors++;
      $display("FAIL reset_mid_hold: ctl=%h expected 0", ctl);
    end
    Clear = 1'b1;
    next_cycle();
    checks++;
    if (ctl !== F0) begin
      errors++;
      $display("FAIL reset_mid_release: ctl=%h expected %h", ctl, F0);
    end
  endtask

  task automatic test_ld_st();
    // ld then st: address phase, then memory read or write.
    for (int k = 0; k < 2; k++) begin
      IR = (k == 0) ? 32'h0080_0010 : 32'h1080_0010;
      clear_exp();
      e[3] = GRB | BAO | YI | RUN;
      e[4] = CO | ZI | RUN;  a[4] = 5'b00011;
      e[5] = ZLO | MARI | RUN;
      e[6] = (k == 0) ? (RD | MDRI | RUN) : (GRA | ROUT | MDRI | RUN);
      e[7] = (k == 0) ? (MDRO | GRA | RIN | RUN) : (WR | RUN);
      e[8] = F0;
      n = 9;
      for (int i = 0; i < n; i++) begin
        if (i > 0) next_cycle();
        checks++;
        if (ctl !== e[i] || (!$isunknown(a[i]) && alu_op !== a[i])) begin
          errors++;
          $display("FAIL %s step %0d: ctl=%h alu=%b, expected ctl=%h alu=%b",
                   (k == 0) ? "ld" : "st", i, ctl, alu_op, e[i], a[i]);
        end
      end
    end
  endtask

  task automatic test_br();
    for (int k = 0; k < 2; k++) begin
      IR = 32'h9080_0004;
      CON_FF = (k == 1);
      clear_exp();
      e[3] = GRA | ROUT | CONI | RUN;
      e[4] = PCO | YI | RUN;
      e[5] = CO | ZI | RUN;  a[5] = 5'b00011;
      e[6] = (k == 1) ? (ZLO | PCI | RUN) : (ZLO | RUN);
      e[7] = F0;
      n = 8;
      for (int i = 0; i < n; i++) begin
        if (i > 0) next_cycle();
        checks++;
        if (ctl !== e[i] || (!$isunknown(a[i]) && alu_op !== a[i])) begin
          errors++;
          $display("FAIL br_con%0d step %0d: ctl=%h alu=%b, expected ctl=%h alu=%b",
                   k, i, ctl, alu_op, e[i], a[i]);
        end
      end
    end
    CON_FF = 1'b0;
  endtask

  task automatic test_other_classes();
    // mul, neg, in, mfhi
    for (int k = 0; k < 4; k++) begin
      clear_exp();
      case (k)
        0: begin
          IR = 32'h7080_0000;
          e[3] = GRA | ROUT | YI | RUN;
          e[4] = GRB | ROUT | ZI | RUN;  a[4] = 5'b01110;
          e[5] = ZLO | LOI | RUN;
          e[6] = ZHO | HII | RUN;
          e[7] = F0; n = 8;
        end
        1: begin
          IR = 32'h8080_0000;
          e[3] = GRB | ROUT | ZI | RUN;  a[3] = 5'b10000;
          e[4] = ZLO | GRA | RIN | RUN;
          e[5] = F0; n = 6;
        end
        2: begin
          IR = 32'hA880_0000;
          e[3] = INO | GRA | RIN | RUN;
          e[4] = F0; n = 5;
        end
        default: begin
          IR = 32'hB880_0000;
          e[3] = HIO | GRA | RIN | RUN;
          e[4] = F0; n = 5;
        end
      endcase
      for (int i = 0; i < n; i++) begin
        if (i > 0) next_cycle();
        checks++;
        if (ctl !== e[i] || (!$isunknown(a[i]) && alu_op !== a[i])) begin
          errors++;
          $display("FAIL class%0d step %0d: ctl=%h alu=%b, expected ctl=%h alu=%b",
                   k, i, ctl, alu_op, e[i], a[i]);
        end
      end
    end
  endtask

  task automatic test_stop_halt();
    // addi with Stop raised during T4: finishes T5 then halts.
    IR = 32'h5880_0007;
    clear_exp();
    e[3] = GRB | ROUT | YI | RUN;
    e[4] = CO | ZI | RUN;  a[4] = 5'b01011;
    e[5] = ZLO | GRA | RIN | RUN;
    e[6] = 28'd0;
    e[7] = 28'd0;
    n = 8;
    for (int i = 0; i < n; i++) begin
      if (i > 0) next_cycle();
      if (i == 4) Stop = 1'b1;
      if (i == 7) Stop = 1'b0;
      checks++;
      if (ctl !== e[i] || (!$isunknown(a[i]) && alu_op !== a[i])) begin
        errors++;
        $display("FAIL stop_addi step %0d: ctl=%h alu=%b, expected ctl=%h alu=%b",
                 i, ctl, alu_op, e[i], a[i]);
      end
    end
    next_cycle();
    checks++;
    if (ctl !== 28'd0) begin
      errors++;
      $display("FAIL stop_held: ctl=%h expected 0", ctl);
    end
    do_reset();
  endtask

  task automatic test_halt_and_undef();
    for (int k = 0; k < 2; k++) begin
      IR = (k == 0) ? 32'hD000_0000 : 32'hF800_0000;
      clear_exp();
      e[3] = (k == 0) ? 28'd0 : F0;
      e[4] = (k == 0) ? 28'd0 : F1;
      n = 5;
      for (int i = 0; i < n; i++) begin
        if (i > 0) next_cycle();
        checks++;
        if (ctl !== e[i]) begin
          errors++;
          $display("FAIL %s step %0d: ctl=%h expected %h",
                   (k == 0) ? "halt_op" : "undef_op", i, ctl, e[i]);
        end
      end
      if (k == 0) do_reset();
      else        next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_reset_mid();
    test_ld_st();
    test_br();
    test_other_classes();
    test_stop_halt();
    test_halt_and_undef();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
